// File: rtl/ccip_edge_tx_pipe.sv
// CCI-P Tx edge pipeline: per-channel FIFO drained through N_STAGES output registers,
// gated by a delayed FIU almost-full. Define CCIP_EDGE_PIPE_STATS_EN to build hwm/af_cycles.

module ccip_edge_tx_chan #(
  parameter  int PAYLOAD_W = 640,
  parameter  int N_STAGES  = 1,
  parameter  int BUF_DEPTH = 16,
  parameter  int AFU_SLACK = 8,
  localparam int AW        = $clog2(BUF_DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 afu_valid_i,
  input  logic [PAYLOAD_W-1:0] afu_payload_i,
  output logic                 afu_almFull_o,
  output logic                 fiu_valid_o,
  output logic [PAYLOAD_W-1:0] fiu_payload_o,
  input  logic                 fiu_almFull_i,
  output logic                 overflow_o,
  output logic [CW-1:0]        hwm_o,
  output logic [31:0]          af_cycles_o
);
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);
  localparam logic [CW-1:0] THR  = CW'(BUF_DEPTH - AFU_SLACK);

  logic [PAYLOAD_W-1:0]               mem_q [BUF_DEPTH];
  logic [AW-1:0]                      wr_q, rd_q;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic [N_STAGES-1:0]                af_sync_q, vld_q;
  logic [N_STAGES-1:0][PAYLOAD_W-1:0] pay_q;
  logic                               afull_q, ovf_q, push, pop, af_q;

  assign af_q = af_sync_q[N_STAGES-1];
  // A full FIFO drops the push even if a pop frees a slot this cycle.
  assign push = afu_valid_i && (cnt_q != FULL);
  assign pop  = (cnt_q != '0) && !af_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      af_sync_q <= '1;
      vld_q     <= '0;
      afull_q   <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      af_sync_q[0] <= fiu_almFull_i;
      vld_q[0]     <= pop;
      for (int k = 1; k < N_STAGES; k++) begin
        af_sync_q[k] <= af_sync_q[k-1];
        vld_q[k]     <= vld_q[k-1];
      end
      afull_q <= (cnt_d >= THR);
      if (afu_valid_i && !push) ovf_q <= 1'b1;
    end
  end

  // Payload path carries no reset; stage 0 loads every cycle and is qualified by vld_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= afu_payload_i;
    pay_q[0] <= mem_q[rd_q];
    for (int k = 1; k < N_STAGES; k++) pay_q[k] <= pay_q[k-1];
  end

  assign afu_almFull_o = afull_q;
  assign fiu_valid_o   = vld_q[N_STAGES-1];
  assign fiu_payload_o = pay_q[N_STAGES-1];
  assign overflow_o    = ovf_q;

`ifdef CCIP_EDGE_PIPE_STATS_EN
  logic [CW-1:0] hwm_q;
  logic [31:0]   afc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hwm_q <= '0;
      afc_q <= '0;
    end else begin
      if (cnt_d > hwm_q) hwm_q <= cnt_d;
      if (afull_q && (afc_q != '1)) afc_q <= afc_q + 32'd1;
    end
  end

  assign hwm_o       = hwm_q;
  assign af_cycles_o = afc_q;
`else
  assign hwm_o       = '0;
  assign af_cycles_o = '0;
`endif
endmodule

module ccip_edge_tx_pipe #(
  parameter  int N_CHAN    = 3,
  parameter  int PAYLOAD_W = 640,
  parameter  int N_STAGES  = 1,
  parameter  int BUF_DEPTH = 16,
  parameter  int AFU_SLACK = 8,
  localparam int HW        = $clog2(BUF_DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_CHAN-1:0]             afu_valid,
  input  logic [N_CHAN*PAYLOAD_W-1:0]   afu_payload,
  output logic [N_CHAN-1:0]             afu_almFull,
  output logic [N_CHAN-1:0]             fiu_valid,
  output logic [N_CHAN*PAYLOAD_W-1:0]   fiu_payload,
  input  logic [N_CHAN-1:0]             fiu_almFull,
  output logic [N_CHAN-1:0]             overflow,
  output logic [N_CHAN*HW-1:0]          hwm,
  output logic [N_CHAN*32-1:0]          af_cycles
);
  for (genvar i = 0; i < N_CHAN; i++) begin : g_chan
    ccip_edge_tx_chan #(
      .PAYLOAD_W (PAYLOAD_W),
      .N_STAGES  (N_STAGES),
      .BUF_DEPTH (BUF_DEPTH),
      .AFU_SLACK (AFU_SLACK)
    ) u_chan (
      .clk           (clk),
      .reset         (reset),
      .afu_valid_i   (afu_valid[i]),
      .afu_payload_i (afu_payload[i*PAYLOAD_W +: PAYLOAD_W]),
      .afu_almFull_o (afu_almFull[i]),
      .fiu_valid_o   (fiu_valid[i]),
      .fiu_payload_o (fiu_payload[i*PAYLOAD_W +: PAYLOAD_W]),
      .fiu_almFull_i (fiu_almFull[i]),
      .overflow_o    (overflow[i]),
      .hwm_o         (hwm[i*HW +: HW]),
      .af_cycles_o   (af_cycles[i*32 +: 32])
    );
  end
endmodule

// File: tb/tb_ccip_edge_tx_pipe.sv
// Bench for ccip_edge_tx_pipe: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.

module tb_ccip_edge_tx_pipe;
  localparam int NC = 3, PW = 640, NS = 1, BD = 16, SL = 8;
  localparam int HW = $clog2(BD) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NC-1:0]     afu_valid = '0;
  logic [NC*PW-1:0]  afu_payload = '0;
  logic [NC-1:0]     fiu_almFull = '0;
  logic [NC-1:0]     afu_almFull, fiu_valid, overflow;
  logic [NC*PW-1:0]  fiu_payload;
  logic [NC*HW-1:0]  hwm;
  logic [NC*32-1:0]  af_cycles;

  int vec = 0;
  int err = 0;

  ccip_edge_tx_pipe #(
    .N_CHAN(NC), .PAYLOAD_W(PW), .N_STAGES(NS), .BUF_DEPTH(BD), .AFU_SLACK(SL)
  ) dut (
    .clk(clk), .reset(reset),
    .afu_valid(afu_valid), .afu_payload(afu_payload), .afu_almFull(afu_almFull),
    .fiu_valid(fiu_valid), .fiu_payload(fiu_payload), .fiu_almFull(fiu_almFull),
    .overflow(overflow), .hwm(hwm), .af_cycles(af_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    vec++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] pay(input int ch, input int n);
    logic [PW-1:0] r;
    r = '0;
    r[31:0]       = n;
    r[400 +: 16]  = 16'(n) ^ 16'hBEEF;
    r[PW-1 -: 8]  = 8'(ch + 1);
    return r;
  endfunction

  // Reference model: FIFO contents as a queue; the almost-full and output
  // registers become "value seen NS cycles ago" delay lines.
  logic [PW-1:0] mq   [NC][$];
  logic          m_fa [NC][NS];
  logic          m_ov [NC][NS];
  logic [PW-1:0] m_op [NC][NS];
  logic          m_aaf[NC];
  logic          m_ovf[NC];
  int            m_hwm[NC];
  longint        m_afc[NC];

  task automatic mreset(input int c);
    mq[c].delete();
    for (int k = 0; k < NS; k++) begin
      m_fa[c][k] = 1'b1;
      m_ov[c][k] = 1'b0;
      m_op[c][k] = '0;
    end
    m_aaf[c] = 1'b1;
    m_ovf[c] = 1'b0;
    m_hwm[c] = 0;
    m_afc[c] = 0;
  endtask

  task automatic madvance();
    for (int c = 0; c < NC; c++) begin
      logic          pop, push;
      logic [PW-1:0] d;
      if (reset) begin
        mreset(c);
        continue;
      end
      d    = '0;
      pop  = (mq[c].size() > 0) && !m_fa[c][NS-1];
      push = afu_valid[c] && (mq[c].size() < BD);
      if (afu_valid[c] && !push) m_ovf[c] = 1'b1;
      if (m_aaf[c] && m_afc[c] < 64'hFFFF_FFFF) m_afc[c]++;
      if (pop)  d = mq[c].pop_front();
      if (push) mq[c].push_back(afu_payload[c*PW +: PW]);
      for (int k = NS - 1; k > 0; k--) begin
        m_fa[c][k] = m_fa[c][k-1];
        m_ov[c][k] = m_ov[c][k-1];
        m_op[c][k] = m_op[c][k-1];
      end
      m_fa[c][0] = fiu_almFull[c];
      m_ov[c][0] = pop;
      m_op[c][0] = d;
      m_aaf[c]   = (mq[c].size() >= BD - SL);
      if (mq[c].size() > m_hwm[c]) m_hwm[c] = mq[c].size();
    end
  endtask

  initial begin
    for (int c = 0; c < NC; c++) mreset(c);
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int c = 0; c < NC; c++) begin
        chk($sformatf("model ch%0d fiu_valid", c), PW'(fiu_valid[c]), PW'(m_ov[c][NS-1]));
        if (m_ov[c][NS-1])
          chk($sformatf("model ch%0d fiu_payload", c), fiu_payload[c*PW +: PW], m_op[c][NS-1]);
        chk($sformatf("model ch%0d afu_almFull", c), PW'(afu_almFull[c]), PW'(m_aaf[c]));
        chk($sformatf("model ch%0d overflow", c), PW'(overflow[c]), PW'(m_ovf[c]));
`ifdef CCIP_EDGE_PIPE_STATS_EN
        chk($sformatf("model ch%0d hwm", c), PW'(hwm[c*HW +: HW]), PW'(m_hwm[c]));
        chk($sformatf("model ch%0d af_cycles", c), PW'(af_cycles[c*32 +: 32]), PW'(32'(m_afc[c])));
`else
        chk($sformatf("model ch%0d hwm", c), PW'(hwm[c*HW +: HW]), '0);
        chk($sformatf("model ch%0d af_cycles", c), PW'(af_cycles[c*32 +: 32]), '0);
`endif
      end
      madvance();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input logic [PW-1:0] p);
    afu_valid[ch] = 1'b1;
    afu_payload[ch*PW +: PW] = p;
  endtask

  initial begin
    int n;
    // Reset and release
    reset = 1'b1;
    repeat (3) tick();
    chk("lit reset afu_almFull", PW'(afu_almFull), PW'(3'b111));
    chk("lit reset fiu_valid", PW'(fiu_valid), '0);
    reset = 1'b0;
    tick();
    chk("lit release afu_almFull", PW'(afu_almFull), '0);
    tick();

    // Single push latency on ch0
    drive(0, PW'(8'hA5));
    tick();
    afu_valid = '0;
    chk("lit lat t+1 fiu_valid", PW'(fiu_valid), '0);
    tick();
    chk("lit lat t+2 fiu_valid", PW'(fiu_valid), PW'(3'b001));
    chk("lit lat t+2 payload", fiu_payload[0 +: PW], PW'(8'hA5));
    tick();
    chk("lit lat t+3 fiu_valid", PW'(fiu_valid), '0);

    // Almost-full hold on ch1, 8 pushes, release and drain
    fiu_almFull[1] = 1'b1;
    repeat (2) tick();
    for (int k = 0; k < 8; k++) begin
      drive(1, pay(1, k));
      tick();
      chk("lit ch1 held fiu_valid", PW'(fiu_valid[1]), '0);
      chk($sformatf("lit ch1 afu_almFull after push %0d", k + 1), PW'(afu_almFull[1]), PW'(k == 7));
    end
    afu_valid = '0;
    tick();
    fiu_almFull[1] = 1'b0;
    tick();
    chk("lit ch1 rel+1 afu_almFull", PW'(afu_almFull[1]), PW'(1'b1));
    chk("lit ch1 rel+1 fiu_valid", PW'(fiu_valid[1]), '0);
    tick();
    chk("lit ch1 rel+2 afu_almFull", PW'(afu_almFull[1]), '0);
`ifdef CCIP_EDGE_PIPE_STATS_EN
    chk("lit ch1 hwm", PW'(hwm[HW +: HW]), PW'(8));
    chk("lit ch1 af_cycles", PW'(af_cycles[32 +: 32]), PW'(4));
`else
    chk("lit ch1 hwm", PW'(hwm[HW +: HW]), '0);
    chk("lit ch1 af_cycles", PW'(af_cycles[32 +: 32]), '0);
`endif
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("lit ch1 drain %0d valid", k), PW'(fiu_valid[1]), PW'(1'b1));
      chk($sformatf("lit ch1 drain %0d payload", k), fiu_payload[PW +: PW], pay(1, k));
      tick();
    end
    chk("lit ch1 drained", PW'(fiu_valid[1]), '0);

    // Overflow on ch2: 17 pushes into a 16-deep FIFO
    fiu_almFull[2] = 1'b1;
    repeat (2) tick();
    for (int k = 0; k < 17; k++) begin
      drive(2, pay(2, k));
      tick();
      chk($sformatf("lit ch2 overflow after push %0d", k + 1), PW'(overflow[2]), PW'(k == 16));
    end
    afu_valid = '0;
    fiu_almFull[2] = 1'b0;
    n = 0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (fiu_valid[2]) begin
        chk($sformatf("lit ch2 drain %0d payload", n), fiu_payload[2*PW +: PW], pay(2, n));
        n++;
      end
    end
    chk("lit ch2 drain count", PW'(n), PW'(16));
    chk("lit ch2 overflow sticky", PW'(overflow[2]), PW'(1'b1));

    // Steady state on ch0: cnt held at 8 with a push and pop every cycle
    fiu_almFull[0] = 1'b1;
    repeat (2) tick();
    for (int k = 0; k < 7; k++) begin
      drive(0, pay(0, k));
      tick();
    end
    drive(0, pay(0, 7));
    fiu_almFull[0] = 1'b0;
    tick();
    for (int j = 0; j < 12; j++) begin
      drive(0, pay(0, 8 + j));
      tick();
      chk($sformatf("lit ch0 steady %0d afu_almFull", j), PW'(afu_almFull[0]), PW'(1'b1));
      chk($sformatf("lit ch0 steady %0d valid", j), PW'(fiu_valid[0]), PW'(1'b1));
      chk($sformatf("lit ch0 steady %0d payload", j), fiu_payload[0 +: PW], pay(0, j));
    end
    afu_valid = '0;
    repeat (12) tick();

    // Mid-operation reset: 5 buffered on ch1, 1 in flight on ch0
    fiu_almFull[1] = 1'b1;
    repeat (2) tick();
    for (int k = 0; k < 5; k++) begin
      drive(1, pay(1, 100 + k));
      if (k == 4) drive(0, pay(0, 200));
      tick();
    end
    afu_valid = '0;
    tick();
    chk("lit rst in-flight valid", PW'(fiu_valid[0]), PW'(1'b1));
    reset = 1'b1;
    tick();
    chk("lit rst fiu_valid", PW'(fiu_valid), '0);
    chk("lit rst afu_almFull", PW'(afu_almFull), PW'(3'b111));
    chk("lit rst overflow", PW'(overflow), '0);
    reset = 1'b0;
    fiu_almFull = '0;
    tick();
    chk("lit rst release afu_almFull", PW'(afu_almFull), '0);
    for (int t = 0; t < 8; t++) begin
      tick();
      chk("lit post-rst idle", PW'(fiu_valid), '0);
    end
    drive(2, pay(2, 300));
    tick();
    afu_valid = '0;
    tick();
    chk("lit post-rst ch2 valid", PW'(fiu_valid), PW'(3'b100));
    chk("lit post-rst ch2 payload", fiu_payload[2*PW +: PW], pay(2, 300));
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
